// File: rtl/alu_res_decoder.sv
// alu_res_decoder: FIFO buffer for packed ALU result words with flag event counters
// and a sticky zero-flag consistency check on every accepted word.
module alu_res_decoder #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CW    = 8
) (
    input  logic                     i_CLK,
    input  logic                     i_RSTn,
    input  logic [WIDTH+2:0]         i_D,
    input  logic                     i_VALID,
    output logic                     o_READY,
    output logic [WIDTH-1:0]         o_RESULT,
    output logic                     o_OVF,
    output logic                     o_CARRY,
    output logic                     o_ZERO,
    output logic                     o_VALID,
    input  logic                     i_READY,
    input  logic                     i_CLR_CNT,
    output logic [CW-1:0]            o_CNT_OVF,
    output logic [CW-1:0]            o_CNT_CARRY,
    output logic [CW-1:0]            o_CNT_ZERO,
    output logic                     o_ERR,
    output logic [$clog2(DEPTH):0]   o_LEVEL
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH+2:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wp, r_rp;
    logic [AW:0]      r_level;
    logic             r_live;
    logic [CW-1:0]    r_cnt_ovf, r_cnt_carry, r_cnt_zero;
    logic             r_err;
    logic             w_push, w_pop, w_bad;
    // r_live holds o_READY low until the first edge after reset release
    assign o_READY     = r_live && (r_level < (AW+1)'(DEPTH));
    assign o_VALID     = r_level != '0;
    assign w_push      = i_VALID && o_READY;
    assign w_pop       = o_VALID && i_READY;
    assign w_bad       = i_D[0] != (i_D[WIDTH+2:3] == '0);
    assign {o_RESULT, o_OVF, o_CARRY, o_ZERO} = r_mem[r_rp];
    assign o_LEVEL     = r_level;
    assign o_CNT_OVF   = r_cnt_ovf;
    assign o_CNT_CARRY = r_cnt_carry;
    assign o_CNT_ZERO  = r_cnt_zero;
    assign o_ERR       = r_err;
    always_ff @(posedge i_CLK) begin
        if (w_push) r_mem[r_wp] <= i_D;
    end
    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_level <= '0;
            r_live  <= 1'b0;
        end else begin
            r_live  <= 1'b1;
            r_wp    <= r_wp + AW'(w_push);
            r_rp    <= r_rp + AW'(w_pop);
            r_level <= r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end
    // Counters saturate at all-ones; clear wins over a same-cycle push
    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            r_cnt_ovf   <= '0;
            r_cnt_carry <= '0;
            r_cnt_zero  <= '0;
            r_err       <= 1'b0;
        end else if (i_CLR_CNT) begin
            r_cnt_ovf   <= '0;
            r_cnt_carry <= '0;
            r_cnt_zero  <= '0;
            r_err       <= 1'b0;
        end else if (w_push) begin
            r_cnt_ovf   <= r_cnt_ovf + CW'(i_D[2] && !(&r_cnt_ovf));
            r_cnt_carry <= r_cnt_carry + CW'(i_D[1] && !(&r_cnt_carry));
            r_cnt_zero  <= r_cnt_zero + CW'(i_D[0] && !(&r_cnt_zero));
            r_err       <= r_err || w_bad;
        end
    end
endmodule
